// File: rtl/exibe_sequencia_pkg.sv
// Shared constants for the game's control units: state codes, default timings, widths.
package exibe_sequencia_pkg;

    localparam int unsigned T_ACESO_PADRAO   = 1000;
    localparam int unsigned T_APAGADO_PADRAO = 500;

    localparam int unsigned TEMPO_W  = 16;
    localparam int unsigned END_W    = 4;
    localparam int unsigned LED_W    = 4;
    localparam int unsigned ESTADO_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        OCIOSO  = 4'd0,
        CARREGA = 4'd1,
        ACESO   = 4'd2,
        APAGADO = 4'd3,
        FIM     = 4'd4
    } estado_t;

endpackage

// File: rtl/exibe_sequencia_contador.sv
// 16-bit up-counter used to time the LED-on and LED-off phases.
module contador_tempo
    import exibe_sequencia_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    input  logic [TEMPO_W-1:0] limite,
    output logic               fim
);

    logic [TEMPO_W-1:0] valor;

    // Count up while enabled; clear has priority over counting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valor <= '0;
        end else if (zera) begin
            valor <= '0;
        end else if (conta) begin
            valor <= valor + TEMPO_W'(1);
        end
    end

    // Terminal count is one below the limit so a phase lasts exactly limite cycles.
    assign fim = (valor == TEMPO_W'(limite - TEMPO_W'(1)));

endmodule

// File: rtl/exibe_sequencia.sv
// Plays memory items 0..rodada on the LEDs, each lit for T_ACESO then dark for T_APAGADO.
module exibe_sequencia
    import exibe_sequencia_pkg::*;
#(
    parameter int unsigned T_ACESO   = T_ACESO_PADRAO,
    parameter int unsigned T_APAGADO = T_APAGADO_PADRAO
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                abortar,
    input  logic [END_W-1:0]    rodada,
    input  logic [LED_W-1:0]    dado_memoria,
    output logic [END_W-1:0]    endereco,
    output logic [LED_W-1:0]    leds,
    output logic                ocupado,
    output logic                pronto,
    output logic [ESTADO_W-1:0] db_estado
);

    estado_t            estado;
    logic [END_W-1:0]   limite;
    logic               zera;
    logic               conta;
    logic               fim_tempo;
    logic [TEMPO_W-1:0] limite_tempo;

    // Timer runs only in the two timed phases and restarts at every phase boundary.
    assign conta        = (estado == ACESO) || (estado == APAGADO);
    assign zera         = abortar || !conta || fim_tempo;
    assign limite_tempo = (estado == APAGADO) ? TEMPO_W'(T_APAGADO) : TEMPO_W'(T_ACESO);
    assign db_estado    = estado;

    contador_tempo u_contador_tempo (
        .clock  (clock),
        .reset  (reset),
        .zera   (zera),
        .conta  (conta),
        .limite (limite_tempo),
        .fim    (fim_tempo)
    );

    // Sequencer FSM with registered outputs; abort wins over every other request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= OCIOSO;
            limite   <= '0;
            endereco <= '0;
            leds     <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
        end else if (abortar) begin
            estado   <= OCIOSO;
            endereco <= '0;
            leds     <= '0;
            ocupado  <= 1'b0;
            pronto   <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    leds     <= '0;
                    endereco <= '0;
                    pronto   <= 1'b0;
                    if (iniciar) begin
                        limite  <= rodada;
                        ocupado <= 1'b1;
                        estado  <= CARREGA;
                    end
                end
                CARREGA: begin
                    leds   <= dado_memoria;
                    estado <= ACESO;
                end
                ACESO: begin
                    if (fim_tempo) begin
                        leds   <= '0;
                        estado <= APAGADO;
                    end
                end
                APAGADO: begin
                    if (fim_tempo) begin
                        if (endereco == limite) begin
                            ocupado <= 1'b0;
                            pronto  <= 1'b1;
                            estado  <= FIM;
                        end else begin
                            endereco <= endereco + END_W'(1);
                            estado   <= CARREGA;
                        end
                    end
                end
                FIM: begin
                    pronto   <= 1'b0;
                    endereco <= '0;
                    estado   <= OCIOSO;
                end
                default: begin
                    leds     <= '0;
                    endereco <= '0;
                    ocupado  <= 1'b0;
                    pronto   <= 1'b0;
                    estado   <= OCIOSO;
                end
            endcase
        end
    end

endmodule
